// File: rtl/seq_arb_4req_rr_hold.sv
// seq_arb_4req_rr_hold: 4-requester round-robin hold arbiter, IDLE/GRANT/FLUSH; SEQ_ARB_TIMEOUT_EN adds max-hold preemption
module seq_arb_4req_rr_hold #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic       busy,
  output logic [1:0] state
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  logic [1:0] owner, ptr, off, winner;
  logic [7:0] cnt, dbl;
  logic [3:0] rot;
  logic       sat, rel, tmo;
  always_comb begin
    dbl    = {req, req} >> ptr;
    rot    = dbl[3:0];
    off    = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    winner = ptr + off;
    sat    = cnt == 8'(MAX_HOLD - 1);
    rel    = done | ~req[owner];
`ifdef SEQ_ARB_TIMEOUT_EN
    tmo    = sat & |(req & ~(4'b1 << owner));
`else
    tmo    = 1'b0;
`endif
    grant  = (state == GRANT) ? 4'b1 << owner : 4'b0;
    busy   = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= 2'd0;
      ptr   <= 2'd0;
      cnt   <= 8'd0;
    end else if (state == IDLE) begin
      if (|req) begin
        owner <= winner;
        cnt   <= 8'd0;
        state <= GRANT;
      end
    end else if (state == GRANT) begin
      if (rel | tmo) begin
        state <= FLUSH;
        ptr   <= owner + 2'd1;
      end else begin
        cnt   <= sat ? cnt : cnt + 8'd1;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule
